// File: rtl/sram_pkg.sv
// ----------------------------------------------------------------------------
// sram_pkg
//   Shared definitions for the sram_1r1w_array slice.
//   - sram_state_t : initialisation state machine encoding (INIT, READY)
//   - merge_lanes  : merges a new word into an old word under a per-lane mask.
//                    The write path and the write-first bypass path both use it.
//
//   merge_lanes works on words zero-extended to MAX_DATA_WIDTH bits and on
//   lane masks zero-extended to MAX_LANES bits. Callers cast their operands up
//   and the result back down. Unused upper lanes carry a zero mask bit, so they
//   never pick up new data.
// ----------------------------------------------------------------------------
package sram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } sram_state_t;

    localparam int MAX_DATA_WIDTH = 1024;
    localparam int MAX_LANES      = 128;

    // Builds a bit-level mask from the lane mask, then selects bit by bit.
    // The lane mask is consumed from its top bit downward while the bit mask
    // shifts left by one lane each step. When the loop ends, lane i sits at
    // bit offset i*lane_width. Only constant bit selects are used.
    function automatic logic [MAX_DATA_WIDTH-1:0] merge_lanes(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_LANES-1:0]      lane_mask,
        input int unsigned               lane_width
    );
        logic [MAX_DATA_WIDTH-1:0] bit_mask;
        logic [MAX_DATA_WIDTH-1:0] lane_ones;
        logic [MAX_LANES-1:0]      remaining;
        lane_ones = ~({MAX_DATA_WIDTH{1'b1}} << lane_width);
        bit_mask  = '0;
        remaining = lane_mask;
        for (int l = 0; l < MAX_LANES; l++) begin
            bit_mask = bit_mask << lane_width;
            if (remaining[MAX_LANES-1]) begin
                bit_mask = bit_mask | lane_ones;
            end
            remaining = remaining << 1;
        end
        return (old_word & ~bit_mask) | (new_word & bit_mask);
    endfunction

endpackage

// File: rtl/sram_init_seq.sv
// ----------------------------------------------------------------------------
// sram_init_seq
//   Initialisation sequencer for sram_1r1w_array. After reset it sweeps the
//   whole array once, asking for a write on every clock edge from address 0
//   up to depth-1. It then settles in READY until the next reset.
//
//   Ports
//     clk       : clock; all state changes happen on its rising edge
//     rst_n     : asynchronous active-low reset; returns to INIT at address 0
//     ready     : registered; high once the sweep has written the last word
//     init_we   : high while the sweep owns the array write port
//     init_addr : address the sweep is writing this cycle
// ----------------------------------------------------------------------------
module sram_init_seq
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ready,
    output logic                  init_we,
    output logic [ADDR_WIDTH-1:0] init_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    sram_state_t           state;
    logic [ADDR_WIDTH-1:0] sweep_addr;

    // The edge that writes LAST_ADDR also moves the machine to READY.
    // ready is therefore first seen high exactly depth edges after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            sweep_addr <= '0;
            ready      <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (sweep_addr == LAST_ADDR) begin
                        state <= READY;
                        ready <= 1'b1;
                    end else begin
                        sweep_addr <= sweep_addr + ADDR_WIDTH'(1);
                    end
                end
                READY: begin
                    state <= READY;
                    ready <= 1'b1;
                end
                default: begin
                    state      <= INIT;
                    sweep_addr <= '0;
                    ready      <= 1'b0;
                end
            endcase
        end
    end

    assign init_we   = (state == INIT);
    assign init_addr = sweep_addr;

endmodule

// File: rtl/sram_1r1w_array.sv
// ----------------------------------------------------------------------------
// sram_1r1w_array
//   Behavioural one-read / one-write SRAM array with a per-lane write mask.
//   Out of reset, sram_init_seq fills every word with INIT_VALUE. The read and
//   write ports are ignored until ready rises. Reads have one cycle of latency:
//   rd_data is a register, and rd_valid marks each new result for one cycle.
//
//   Build option
//     SRAM_1R1W_BYPASS_EN : when defined, a read and a write to the same
//                           address in the same cycle return the merged new
//                           word (write-first). When undefined, they return
//                           the old contents (read-first).
//
//   Ports
//     clk      : clock
//     rst_n    : asynchronous active-low reset (array contents not cleared)
//     ready    : high once the init sweep is complete
//     rd_csb   : active-low read chip select
//     rd_addr  : read address
//     rd_data  : registered read data, holds between reads
//     rd_valid : one-cycle strobe when rd_data carries a new result
//     wr_csb   : active-low write chip select
//     wr_addr  : write address
//     wr_mask  : per-lane write enable, bit i covers lane i
//     wr_data  : write data
//
//   DATA_WIDTH must be a multiple of NUM_WMASKS and no larger than
//   sram_pkg::MAX_DATA_WIDTH. NUM_WMASKS must not exceed sram_pkg::MAX_LANES.
// ----------------------------------------------------------------------------
module sram_1r1w_array
    import sram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 256,
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    NUM_WMASKS = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ready,
    input  logic                  rd_csb,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_csb,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WMASKS-1:0] wr_mask,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int          DEPTH      = 2 ** ADDR_WIDTH;
    localparam int unsigned LANE_WIDTH = DATA_WIDTH / NUM_WMASKS;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  init_we;
    logic [ADDR_WIDTH-1:0] init_addr;

    logic                  wr_fire;
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] read_word;

    logic                  array_we;
    logic [ADDR_WIDTH-1:0] array_addr;
    logic [DATA_WIDTH-1:0] array_word;

    sram_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .ready     (ready),
        .init_we   (init_we),
        .init_addr (init_addr)
    );

    // The ports only count once the sweep has finished.
    assign wr_fire = ready & ~wr_csb;
    assign rd_fire = ready & ~rd_csb;

    // A masked write is a read-modify-write of the addressed word.
    assign wr_merged = DATA_WIDTH'(merge_lanes(MAX_DATA_WIDTH'(mem[wr_addr]),
                                               MAX_DATA_WIDTH'(wr_data),
                                               MAX_LANES'(wr_mask),
                                               LANE_WIDTH));

    // The sweep and the write port share the single array write port.
    // They never overlap because the port is gated by ready. No write happens
    // while reset is held, so an aborted operation leaves the array untouched.
    always_comb begin
        array_we   = 1'b0;
        array_addr = wr_addr;
        array_word = wr_merged;
        if (init_we) begin
            array_we   = rst_n;
            array_addr = init_addr;
            array_word = INIT_VALUE;
        end else if (wr_fire) begin
            array_we   = rst_n;
        end
    end

    // Storage has no reset; its contents come only from the sweep and the port.
    always_ff @(posedge clk) begin
        if (array_we) begin
            mem[array_addr] <= array_word;
        end
    end

`ifdef SRAM_1R1W_BYPASS_EN
    // Write-first: on a same-address collision, return the word as it will
    // be after this edge's write.
    logic collide;
    assign collide = wr_fire && (wr_addr == rd_addr);

    always_comb begin
        read_word = mem[rd_addr];
        if (collide) begin
            read_word = DATA_WIDTH'(merge_lanes(MAX_DATA_WIDTH'(mem[rd_addr]),
                                                MAX_DATA_WIDTH'(wr_data),
                                                MAX_LANES'(wr_mask),
                                                LANE_WIDTH));
        end
    end
`else
    // Read-first: the array is sampled before this edge's write lands.
    assign read_word = mem[rd_addr];
`endif

    // rd_data only changes on an accepted read, so it holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= read_word;
            end
        end
    end

endmodule
